// File: rtl/comb_decimator_pkg.sv
// comb_decimator_pkg: shared sizing helpers for the comb decimator
package comb_decimator_pkg;
  function automatic int cnt_w(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction
endpackage

// File: rtl/delay_line.sv
// delay_line: async-cleared shift register of past kept samples, returns the oldest
module delay_line #(
  parameter int m = 17,
  parameter int d = 1
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         shift,
  input  logic [m-1:0] din,
  output logic [m-1:0] dout
);
  logic [m-1:0] hist [d];
  // shift a new kept sample in on each decimation event
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) for (int i = 0; i < d; i++) hist[i] <= '0;
    else if (shift) begin
      hist[0] <= din;
      for (int i = 1; i < d; i++) hist[i] <= hist[i-1];
    end
  assign dout = hist[d-1];
endmodule

// File: rtl/comb_decimator.sv
// comb_decimator: keeps one sample in r and outputs its modular difference to the one kept d periods earlier
module comb_decimator
  import comb_decimator_pkg::*;
#(
  parameter int m = 17,
  parameter int r = 4,
  parameter int d = 1
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  input  logic [m-1:0] in,
  output logic [m-1:0] out,
  output logic         stb
);
  localparam int cw = cnt_w(r);
  localparam logic [cw-1:0] last = cw'(r - 1);
  generate
    if (m < 1 || r < 1 || r > 256 || d < 1 || d > 4) begin : g_bad_param
      $error("comb_decimator: parameter out of range");
    end
  endgenerate
  logic [cw-1:0] phase;
  logic [m-1:0]  old;
  logic          dec;
  assign dec = en && phase == last;
  // count accepted samples modulo r; holds while en is low
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) phase <= '0;
    else if (en) phase <= dec ? '0 : phase + 1'b1;
  // comb difference wraps modulo 2^m so upstream integrator overflow cancels
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      out <= '0;
      stb <= 1'b0;
    end else begin
      stb <= dec;
      if (dec) out <= in - old;
    end
  delay_line #(.m(m), .d(d)) u_hist (
    .clk  (clk),
    .clr_n(clr_n),
    .shift(dec),
    .din  (in),
    .dout (old)
  );
endmodule

// File: tb/tb_comb_decimator.sv
// tb_comb_decimator: scoreboard bench running three comb_decimator configurations side by side
module tb_comb_decimator;
  localparam int RS [3] = '{4, 4, 1};
  localparam int DS [3] = '{1, 2, 1};
  logic       clk = 1'b0;
  logic       clr_n = 1'b1;
  logic       en = 1'b0;
  logic [7:0] in = 8'd0;
  logic [7:0] outs [3];
  logic       stbs [3];
  int         checks = 0;
  int         passed = 0;
  int         cnt [3];
  logic [7:0] kept [3][$];
  logic [7:0] exp_q [3][$];

  always #5 clk = ~clk;

  comb_decimator #(.m(8), .r(4), .d(1)) u_r4d1 (.clk(clk), .clr_n(clr_n), .en(en), .in(in), .out(outs[0]), .stb(stbs[0]));
  comb_decimator #(.m(8), .r(4), .d(2)) u_r4d2 (.clk(clk), .clr_n(clr_n), .en(en), .in(in), .out(outs[1]), .stb(stbs[1]));
  comb_decimator #(.m(8), .r(1), .d(1)) u_r1d1 (.clk(clk), .clr_n(clr_n), .en(en), .in(in), .out(outs[2]), .stb(stbs[2]));

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act == want) passed++;
    else $display("FAIL %s: got %0d, want %0d", name, act, want);
  endtask

  // reference: every r-th accepted sample is kept; output = kept - kept d periods ago (zero if none yet)
  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      cnt[k] = 0;
      kept[k].delete();
      exp_q[k].delete();
    end
  endtask

  task automatic drive(input logic e, input logic [7:0] v);
    logic [7:0] h, diff;
    @(posedge clk);
    #1;
    en = e;
    in = v;
    if (e)
      for (int k = 0; k < 3; k++) begin
        cnt[k]++;
        if (cnt[k] == RS[k]) begin
          cnt[k] = 0;
          h = (kept[k].size() >= DS[k]) ? kept[k][kept[k].size() - DS[k]] : 8'd0;
          diff = v - h;
          exp_q[k].push_back(diff);
          kept[k].push_back(v);
          if (kept[k].size() > 4) void'(kept[k].pop_front());
        end
      end
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    #2;
    clr_n = 1'b0;
    en = 1'b0;
    model_clear();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d reset out", k), int'(outs[k]), 0);
      chk($sformatf("dut%0d reset stb", k), int'(stbs[k]), 0);
    end
    @(negedge clk);
    #2;
    clr_n = 1'b1;
  endtask

  task automatic end_phase();
    drive(1'b0, 8'd0);
    drive(1'b0, 8'd0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("dut%0d outputs drained", k), exp_q[k].size(), 0);
  endtask

  // monitor: every strobe must match the oldest outstanding expectation
  always @(negedge clk)
    if (clr_n)
      for (int k = 0; k < 3; k++)
        if (stbs[k]) begin
          if (exp_q[k].size() == 0) chk($sformatf("dut%0d unexpected stb", k), 1, 0);
          else chk($sformatf("dut%0d out", k), int'(outs[k]), int'(exp_q[k].pop_front()));
        end

  initial begin
    logic [7:0] v;
    logic got;
    model_clear();
    rst_pulse();
    v = 8'd0;
    for (int i = 0; i < 40; i++) begin drive(1'b1, v); v += 8'd3; end
    end_phase();
    rst_pulse();
    v = 8'd100;
    for (int i = 0; i < 40; i++) begin drive(1'b1, v); v += 8'd5; end
    end_phase();
    rst_pulse();
    v = 8'd0;
    for (int i = 0; i < 40; i++) begin drive(1'b1, v); v += 8'd1; end
    end_phase();
    rst_pulse();
    v = 8'd0;
    for (int i = 0; i < 48; i++) begin
      drive(i % 2 == 0, v);
      if (i % 2 == 0) v += 8'd1;
    end
    end_phase();
    rst_pulse();
    v = 8'd0;
    for (int i = 0; i < 4; i++) begin drive(1'b1, v); v += 8'd1; end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = stbs[0];
    end
    chk("stb before mid reset", int'(got), 1);
    #2;
    clr_n = 1'b0;
    en = 1'b0;
    model_clear();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d mid reset stb", k), int'(stbs[k]), 0);
      chk($sformatf("dut%0d mid reset out", k), int'(outs[k]), 0);
    end
    @(negedge clk);
    #2;
    clr_n = 1'b1;
    v = 8'd50;
    for (int i = 0; i < 12; i++) begin drive(1'b1, v); v += 8'd1; end
    end_phase();
    rst_pulse();
    for (int i = 0; i < 12; i++) drive(1'b1, 8'd42);
    end_phase();
    rst_pulse();
    for (int i = 0; i < 300; i++) drive($urandom_range(0, 3) != 0, 8'($urandom));
    end_phase();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
